// File: rtl/i_victim_cache_repl.sv
// Replacement and occupancy controller for the 8-entry instruction victim cache:
// valid bits, 3-level tree pseudo-LRU, occupancy count and eviction flagging.
module i_victim_cache_repl #(
  parameter int WAYS_VC      = 8,
  parameter int INDEX_WAY_VC = 3
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    flush_i,
  input  logic                    hit_i,
  input  logic [INDEX_WAY_VC-1:0] hit_way_i,
  input  logic                    swap_i,
  input  logic                    fill_i,
  input  logic                    inv_i,
  input  logic [INDEX_WAY_VC-1:0] inv_way_i,
  output logic [INDEX_WAY_VC-1:0] victim_way_o,
  output logic                    full_o,
  output logic [3:0]              count_o,
  output logic                    evict_o,
  output logic [INDEX_WAY_VC-1:0] evict_way_o
);

  logic [WAYS_VC-1:0]      valid_r, valid_n_s;
  logic [6:0]              plru_r, plru_n_s;
  logic [3:0]              count_r, count_n_s;
  logic                    evict_r, evict_n_s;
  logic [INDEX_WAY_VC-1:0] evict_way_r, evict_way_n_s;
  logic [INDEX_WAY_VC-1:0] first_free_s, plru_pick_s, victim_s;

  // Point every tree node on the path to `way` away from it (0 selects the lower half).
  function automatic logic [6:0] plru_touch(input logic [6:0] plru, input logic [2:0] way);
    logic [6:0] t;
    t = plru;
    t[3'd0]                         = ~way[2];
    t[3'd1 + {2'b00, way[2]}]       = ~way[1];
    t[3'd3 + {1'b0, way[2:1]}]      = ~way[0];
    return t;
  endfunction

  // Follow the tree from the root to the least-recently-used leaf.
  function automatic logic [2:0] plru_pick(input logic [6:0] plru);
    logic v2, v1, v0;
    v2 = plru[3'd0];
    v1 = plru[3'd1 + {2'b00, v2}];
    v0 = plru[3'd3 + {1'b0, v2, v1}];
    return {v2, v1, v0};
  endfunction

  // Lowest-index invalid entry; only used when the cache is not full.
  always_comb begin
    first_free_s = 3'd0;
    for (int i = WAYS_VC - 1; i >= 0; i--) begin
      if (!valid_r[i]) begin
        first_free_s = 3'(i);
      end else begin
        first_free_s = first_free_s;
      end
    end
  end

  assign plru_pick_s = plru_pick(plru_r);
  assign victim_s    = (&valid_r) ? plru_pick_s : first_free_s;

  // Next-state: flush > fill > hit > inv, each event completes in one cycle.
  always_comb begin
    valid_n_s     = valid_r;
    plru_n_s      = plru_r;
    count_n_s     = count_r;
    evict_n_s     = 1'b0;
    evict_way_n_s = evict_way_r;
    if (flush_i) begin
      valid_n_s = '0;
      plru_n_s  = 7'd0;
      count_n_s = 4'd0;
    end else if (fill_i) begin
      if (hit_i && swap_i) begin
        // Swap: the L1 victim lands in the slot the hit line vacates.
        plru_n_s = plru_touch(plru_r, hit_way_i);
      end else begin
        plru_n_s            = plru_touch(plru_r, victim_s);
        valid_n_s[victim_s] = 1'b1;
        if (valid_r[victim_s]) begin
          evict_n_s     = 1'b1;
          evict_way_n_s = victim_s;
        end else begin
          count_n_s = count_r + 4'd1;
        end
      end
    end else if (hit_i) begin
      plru_n_s = plru_touch(plru_r, hit_way_i);
      if (swap_i && valid_r[hit_way_i]) begin
        valid_n_s[hit_way_i] = 1'b0;
        count_n_s            = count_r - 4'd1;
      end else begin
        count_n_s = count_r;
      end
    end else if (inv_i) begin
      if (valid_r[inv_way_i]) begin
        valid_n_s[inv_way_i] = 1'b0;
        count_n_s            = count_r - 4'd1;
      end else begin
        count_n_s = count_r;
      end
    end else begin
      count_n_s = count_r;
    end
  end

  // State registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_r     <= '0;
      plru_r      <= 7'd0;
      count_r     <= 4'd0;
      evict_r     <= 1'b0;
      evict_way_r <= 3'd0;
    end else begin
      valid_r     <= valid_n_s;
      plru_r      <= plru_n_s;
      count_r     <= count_n_s;
      evict_r     <= evict_n_s;
      evict_way_r <= evict_way_n_s;
    end
  end

  assign victim_way_o = victim_s;
  assign full_o       = &valid_r;
  assign count_o      = count_r;
  assign evict_o      = evict_r;
  assign evict_way_o  = evict_way_r;

endmodule
